// File: rtl/alu_pkg.sv
// Shared definitions for the registered 16-bit ALU: opcodes, flag positions,
// default width and the shifter mode encoding.
package alu_pkg;

    localparam int WIDTH_DEFAULT = 16;

    // Operation select codes carried on salu
    localparam logic [3:0] OP_IADD  = 4'b0000;
    localparam logic [3:0] OP_ISUB  = 4'b0001;
    localparam logic [3:0] OP_IINC  = 4'b0010;
    localparam logic [3:0] OP_IDEC  = 4'b0011;
    localparam logic [3:0] OP_INEG  = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_XOR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1000;
    localparam logic [3:0] OP_SLL   = 4'b1001;
    localparam logic [3:0] OP_SRL   = 4'b1010;
    localparam logic [3:0] OP_SRA   = 4'b1011;
    localparam logic [3:0] OP_ROL   = 4'b1100;
    localparam logic [3:0] OP_ROR   = 4'b1101;
    localparam logic [3:0] OP_PASSA = 4'b1110;
    localparam logic [3:0] OP_PASSB = 4'b1111;

    // Bit positions inside fout = {S, Z, C, V}
    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Shift amount width (b[3:0])
    localparam int AMT_W = 4;

    typedef enum logic [2:0] {
        SH_SLL = 3'd0,
        SH_SRL = 3'd1,
        SH_SRA = 3'd2,
        SH_ROL = 3'd3,
        SH_ROR = 3'd4
    } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter/rotator. Each operation is done on a
// double-width word so the last bit pushed out lands at a fixed position,
// which gives the carry-out without a per-amount index calculation.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amount,
    input  shift_mode_e      mode,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [2*WIDTH-1:0] sll_ext_s;
    logic [2*WIDTH-1:0] srl_ext_s;
    logic [2*WIDTH-1:0] sra_ext_s;
    logic [2*WIDTH-1:0] rol_ext_s;
    logic [2*WIDTH-1:0] ror_ext_s;
    logic               amt_zero_s;

    assign sll_ext_s  = {{WIDTH{1'b0}}, a} << amount;
    assign srl_ext_s  = {a, {WIDTH{1'b0}}} >> amount;
    assign sra_ext_s  = $signed({a, {WIDTH{1'b0}}}) >>> amount;
    assign rol_ext_s  = {a, a} << amount;
    assign ror_ext_s  = {a, a} >> amount;
    assign amt_zero_s = (amount == {AMT_W{1'b0}});

    // Select the shifted word and the last bit moved out; zero amount yields carry 0
    always_comb begin
        result = a;
        carry  = 1'b0;
        case (mode)
            SH_SLL: begin
                result = sll_ext_s[WIDTH-1:0];
                carry  = sll_ext_s[WIDTH];
            end
            SH_SRL: begin
                result = srl_ext_s[2*WIDTH-1:WIDTH];
                carry  = srl_ext_s[WIDTH-1];
            end
            SH_SRA: begin
                result = sra_ext_s[2*WIDTH-1:WIDTH];
                carry  = sra_ext_s[WIDTH-1];
            end
            SH_ROL: begin
                result = rol_ext_s[2*WIDTH-1:WIDTH];
                carry  = amt_zero_s ? 1'b0 : rol_ext_s[WIDTH];
            end
            SH_ROR: begin
                result = ror_ext_s[WIDTH-1:0];
                carry  = amt_zero_s ? 1'b0 : ror_ext_s[WIDTH-1];
            end
            default: begin
                result = a;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered ALU: one shared adder for add/subtract/inc/dec/negate, a logic
// mux, and the barrel shifter; result and {S,Z,C,V} flags update every edge.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       salu,
    output logic [WIDTH-1:0] aout,
    output logic [3:0]       fout
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] add_x_s;
    logic [WIDTH-1:0] add_y_s;
    logic             add_cin_s;
    logic [WIDTH-1:0] add_sum_s;
    logic             add_c_s;
    logic             add_v_s;

    shift_mode_e      sh_mode_s;
    logic [WIDTH-1:0] sh_res_s;
    logic             sh_c_s;

    logic [WIDTH-1:0] next_res_s;
    logic             next_c_s;
    logic             next_v_s;
    logic [3:0]       next_flags_s;

    logic [WIDTH-1:0] aout_r;
    logic [3:0]       fout_r;

    // Adder operand steering: subtract-class ops become x + ~y + 1
    always_comb begin
        add_x_s   = a;
        add_y_s   = b;
        add_cin_s = 1'b0;
        case (salu)
            OP_IADD: begin add_x_s = a;               add_y_s = b;    add_cin_s = 1'b0; end
            OP_ISUB: begin add_x_s = a;               add_y_s = ~b;   add_cin_s = 1'b1; end
            OP_IINC: begin add_x_s = a;               add_y_s = ONE;  add_cin_s = 1'b0; end
            OP_IDEC: begin add_x_s = a;               add_y_s = ~ONE; add_cin_s = 1'b1; end
            OP_INEG: begin add_x_s = {WIDTH{1'b0}};   add_y_s = ~a;   add_cin_s = 1'b1; end
            default: begin add_x_s = a;               add_y_s = b;    add_cin_s = 1'b0; end
        endcase
    end

    assign {add_c_s, add_sum_s} = {1'b0, add_x_s} + {1'b0, add_y_s} + {{WIDTH{1'b0}}, add_cin_s};
    // Same-sign inputs to the adder with a differently signed sum is overflow
    assign add_v_s = (add_x_s[WIDTH-1] == add_y_s[WIDTH-1]) &&
                     (add_sum_s[WIDTH-1] != add_x_s[WIDTH-1]);

    // Map shift/rotate opcodes onto the shifter mode
    always_comb begin
        case (salu)
            OP_SLL:  sh_mode_s = SH_SLL;
            OP_SRL:  sh_mode_s = SH_SRL;
            OP_SRA:  sh_mode_s = SH_SRA;
            OP_ROL:  sh_mode_s = SH_ROL;
            OP_ROR:  sh_mode_s = SH_ROR;
            default: sh_mode_s = SH_SLL;
        endcase
    end

    alu_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .a      (a),
        .amount (b[AMT_W-1:0]),
        .mode   (sh_mode_s),
        .result (sh_res_s),
        .carry  (sh_c_s)
    );

    // Result/carry/overflow selection per opcode
    always_comb begin
        next_res_s = {WIDTH{1'b0}};
        next_c_s   = 1'b0;
        next_v_s   = 1'b0;
        case (salu)
            OP_IADD, OP_ISUB, OP_IINC, OP_IDEC, OP_INEG: begin
                next_res_s = add_sum_s;
                next_c_s   = add_c_s;
                next_v_s   = add_v_s;
            end
            OP_AND:   next_res_s = a & b;
            OP_OR:    next_res_s = a | b;
            OP_XOR:   next_res_s = a ^ b;
            OP_NOT:   next_res_s = ~a;
            OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: begin
                next_res_s = sh_res_s;
                next_c_s   = sh_c_s;
            end
            OP_PASSA: next_res_s = a;
            OP_PASSB: next_res_s = b;
            default:  next_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Pack flags into their fixed positions
    always_comb begin
        next_flags_s         = 4'b0000;
        next_flags_s[FLAG_S] = next_res_s[WIDTH-1];
        next_flags_s[FLAG_Z] = (next_res_s == {WIDTH{1'b0}});
        next_flags_s[FLAG_C] = next_c_s;
        next_flags_s[FLAG_V] = next_v_s;
    end

    // Output register: loads every edge, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aout_r <= {WIDTH{1'b0}};
            fout_r <= 4'b0000;
        end else begin
            aout_r <= next_res_s;
            fout_r <= next_flags_s;
        end
    end

    assign aout = aout_r;
    assign fout = fout_r;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, reset/latency checks and
// randomized operations compared with an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  salu;
    logic [15:0] aout;
    logic [3:0]  fout;

    int total = 0;
    int bad   = 0;

    alu #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .salu  (salu),
        .aout  (aout),
        .fout  (fout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model from the arithmetic rules (signed/unsigned integer ranges, bit-by-bit shifting)
    task automatic ref_alu(input logic [15:0] x, input logic [15:0] y, input logic [3:0] op,
                           output logic [15:0] r, output logic [3:0] f);
        int ux, uy, sx, sy, full, sfull, n;
        logic c, v;
        logic [15:0] t;
        logic signed [15:0] xs, ys;
        xs = x; ys = y;
        ux = int'(x); uy = int'(y); sx = int'(xs); sy = int'(ys);
        c = 1'b0; v = 1'b0; r = 16'h0000; t = x; n = int'(y[3:0]);
        case (op)
            4'd0, 4'd2: begin
                if (op == 4'd2) begin uy = 1; sy = 1; end
                full = ux + uy; sfull = sx + sy;
                r = 16'(full); c = (full > 65535);
                v = (sfull > 32767) || (sfull < -32768);
            end
            4'd1, 4'd3, 4'd4: begin
                if (op == 4'd3) begin uy = 1; sy = 1; end
                if (op == 4'd4) begin uy = ux; sy = sx; ux = 0; sx = 0; end
                full = ux - uy; sfull = sx - sy;
                r = 16'(full); c = (ux >= uy);
                v = (sfull > 32767) || (sfull < -32768);
            end
            4'd5: r = x & y;
            4'd6: r = x | y;
            4'd7: r = x ^ y;
            4'd8: r = ~x;
            4'd9:  begin for (int i = 0; i < n; i++) begin c = t[15]; t = {t[14:0], 1'b0}; end r = t; end
            4'd10: begin for (int i = 0; i < n; i++) begin c = t[0]; t = {1'b0, t[15:1]}; end r = t; end
            4'd11: begin for (int i = 0; i < n; i++) begin c = t[0]; t = {t[15], t[15:1]}; end r = t; end
            4'd12: begin for (int i = 0; i < n; i++) begin c = t[15]; t = {t[14:0], t[15]}; end r = t; end
            4'd13: begin for (int i = 0; i < n; i++) begin c = t[0]; t = {t[0], t[15:1]}; end r = t; end
            4'd14: r = x;
            default: r = y;
        endcase
        f = {r[15], (r == 16'h0000), c, v};
    endtask

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic [3:0] op);
        @(negedge clk);
        a = x; b = y; salu = op;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic [3:0] op, input logic [15:0] er, input logic [3:0] ef);
        drive(x, y, op);
        check_val({tag, "_aout"}, 32'(aout), 32'(er));
        check_val({tag, "_fout"}, 32'(fout), 32'(ef));
    endtask

    initial begin
        logic [15:0] er, ra, rb;
        logic [3:0]  ef, rop;
        logic [15:0] corner [8];
        corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000; corner[3] = 16'h7FFF;
        corner[4] = 16'h0001; corner[5] = 16'h8001; corner[6] = 16'h0010; corner[7] = 16'hAAAA;

        a = 16'h1234; b = 16'h4321; salu = 4'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_aout", 32'(aout), 32'h0);
        check_val("reset_fout", 32'(fout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        directed("add_5_8",       16'd5,     16'd8,     4'd0, 16'd13,    4'b0000);
        directed("add_1234_4321", 16'd1234,  16'd4321,  4'd0, 16'd5555,  4'b0000);
        directed("add_ovf",       16'd20000, 16'd20000, 4'd0, 16'd40000, 4'b1001);
        directed("add_c_v",       16'd40000, 16'd40000, 4'd0, 16'd14464, 4'b0011);
        directed("add_c",         16'd12345, 16'd54321, 4'd0, 16'd1130,  4'b0010);
        directed("add_zero",      16'd30000, 16'd35536, 4'd0, 16'd0,     4'b0110);
        directed("sub_5_8",       16'd5,     16'd8,     4'd1, 16'hFFFD,  4'b1000);
        directed("sub_8000_1",    16'h8000,  16'd1,     4'd1, 16'h7FFF,  4'b0011);
        directed("inc_ffff",      16'hFFFF,  16'd0,     4'd2, 16'h0000,  4'b0110);
        directed("neg_8000",      16'h8000,  16'd0,     4'd4, 16'h8000,  4'b1001);
        directed("neg_0",         16'h0000,  16'd0,     4'd4, 16'h0000,  4'b0110);
        directed("sra_8001",      16'h8001,  16'd1,     4'd11, 16'hC000, 4'b1010);
        directed("rol_8001",      16'h8001,  16'd4,     4'd12, 16'h0018, 4'b0000);
        directed("sll_amt0",      16'h8421,  16'h0010,  4'd9,  16'h8421, 4'b1000);
        directed("ror_1",         16'h0001,  16'd1,     4'd13, 16'h8000, 4'b1010);
        directed("srl_15",        16'h8000,  16'd15,    4'd10, 16'h0001, 4'b0000);

        // Latency: result held until the next edge after salu changes
        drive(16'h0F0F, 16'h0101, 4'd0);
        @(negedge clk);
        salu = 4'd7;
        #1;
        check_val("lat_hold", 32'(aout), 32'h1010);
        @(posedge clk);
        #1;
        check_val("lat_xor", 32'(aout), 32'h0E0E);

        // Mid-stream asynchronous reset, then first result after release
        drive(16'd5, 16'd8, 4'd0);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_aout", 32'(aout), 32'h0);
        check_val("arst_fout", 32'(fout), 32'h0);
        @(posedge clk);
        #1;
        check_val("arst_hold", 32'(aout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        a = 16'd100; b = 16'd23; salu = 4'd0;
        @(posedge clk);
        #1;
        check_val("post_rst_aout", 32'(aout), 32'd123);
        check_val("post_rst_fout", 32'(fout), 32'h0);

        // Randomized operations, mixing in corner operand values
        for (int k = 0; k < 400; k++) begin
            ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : 16'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : 16'($urandom);
            rop = 4'($urandom);
            ref_alu(ra, rb, rop, er, ef);
            drive(ra, rb, rop);
            check_val($sformatf("rnd%0d_op%0d_aout", k, rop), 32'(aout), 32'(er));
            check_val($sformatf("rnd%0d_op%0d_fout", k, rop), 32'(fout), 32'(ef));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 16, data width of a, b and aout; all values and requirements below are for WIDTH=16.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 a  input  WIDTH  operand A.
REQ-005 b  input  WIDTH  operand B; b[3:0] is the shift/rotate amount for shift ops.
REQ-006 salu  input  4  operation select.
REQ-007 aout  output  WIDTH  registered result.
REQ-008 fout  output  4  registered flags {S, Z, C, V}: fout[3]=sign, fout[2]=zero, fout[1]=carry, fout[0]=overflow.

Function
REQ-009 Operation codes: 0000 IADD a+b; 0001 ISUB a-b; 0010 IINC a+1; 0011 IDEC a-1; 0100 INEG 0-a; 0101 AND; 0110 OR; 0111 XOR; 1000 NOT a; 1001 SLL; 1010 SRL; 1011 SRA; 1100 ROL; 1101 ROR; 1110 PASSA; 1111 PASSB.
REQ-010 Latency is one cycle: the result and flags of a, b and salu sampled at rising edge N are visible on aout/fout after edge N; there is no handshake.
REQ-011 Every rising edge with rst_n high loads a new result; there is no enable and no hold.
REQ-012 Arithmetic wraps modulo 2^16, with no saturation.
REQ-013 S = aout[15] and Z = (aout == 0) for all operations.
REQ-014 Add-class ops (IADD, IINC): C = carry out of bit 15; V = 1 when both operands have the same sign and the result sign differs.
REQ-015 Subtract-class ops (ISUB, IDEC, INEG) are computed as x + ~y + 1: C = carry out of bit 15 (1 = no borrow); V = 1 when the operand signs differ and the result sign differs from x.
REQ-016 Logic ops, NOT, PASSA and PASSB: C = 0, V = 0.
REQ-017 SLL/SRL shift in zeros; SRA replicates a[15]; the amount is b[3:0] (0..15) and b[15:4] is ignored.
REQ-018 Shifts and rotates: C = last bit shifted/rotated out, and C = 0 when the amount is 0; V = 0.
REQ-019 ROL/ROR rotate a by b[3:0]; an amount of 0 passes a unchanged.
REQ-020 Boundaries: 0xFFFF+1 gives aout=0 with Z=1, C=1; INEG of 0x8000 gives 0x8000 with V=1; INEG of 0 gives 0 with C=1, Z=1.

Reset
REQ-021 While rst_n is low, aout = 0x0000 and fout = 0000 immediately, independent of clk.
REQ-022 An assertion of rst_n mid-stream discards the pending result; the first result after deassertion comes from inputs sampled at the first rising edge with rst_n high.

Structure
REQ-023 A shared package alu_pkg holds the 4-bit opcode constants, the flag bit indices (S=3, Z=2, C=1, V=0) and the WIDTH default.
REQ-024 Combinational barrel shifter/rotator is one sub-module, alu_shifter (inputs a, amount, mode; outputs result, carry-out); the rest is the adder/logic mux plus the output register in alu.

Verification
REQ-025 IADD: a=5, b=8 -> aout=13, fout=0000; a=1234, b=4321 -> aout=5555, fout=0000.
REQ-026 IADD overflow and carry: a=20000, b=20000 -> aout=40000, fout=1001; a=40000, b=40000 -> aout=14464, fout=0011; a=12345, b=54321 -> aout=1130, fout=0010; a=30000, b=35536 -> aout=0, fout=0110.
REQ-027 ISUB: a=5, b=8 -> aout=0xFFFD, fout=1000; a=0x8000, b=1 -> aout=0x7FFF, fout=0011.
REQ-028 Shifts and rotates: SRA a=0x8001, b=1 -> aout=0xC000, fout=1010; ROL a=0x8001, b=4 -> aout=0x0018, fout=0000; SLL with b=0x0010 (amount 0) -> aout=a, C=0.
REQ-029 Reset: assert rst_n low between clock edges while aout is non-zero -> aout=0 and fout=0000 immediately; after release, the first edge loads the correct result.
REQ-030 Latency: change salu from IADD to XOR between edges -> aout keeps the IADD result until the next rising edge, then shows a^b.
